// File: rtl/register_file_pipelined_pkg.sv
// Shared definitions for the pipelined register file: sweep FSM encodings and default widths.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    DONE  = 2'b10
  } sweep_state_t;

endpackage

// File: rtl/register_file_pipelined_if.sv
// Read/write/sweep bus of the pipelined register file; slave is the register file itself.
interface register_file_pipelined_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic              rd_en;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              read_valid;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              regWrite;
  logic              write_ready;
  logic              sweep_req;
  logic              sweep_busy;
  logic              sweep_done;

  modport master (
    output read_reg1, read_reg2, rd_en, write_reg, write_data, regWrite, sweep_req,
    input  read_data1, read_data2, read_valid, write_ready, sweep_busy, sweep_done
  );

  modport slave (
    input  read_reg1, read_reg2, rd_en, write_reg, write_data, regWrite, sweep_req,
    output read_data1, read_data2, read_valid, write_ready, sweep_busy, sweep_done
  );

endinterface

// File: rtl/register_file_pipelined_sweep_ctrl.sv
// Sweep-clear sequencer: walks a pointer over every entry, one per cycle, then pulses done.
module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              sweep_req,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic              write_ready,
  output logic              sweep_wr_en,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  sweep_state_t      state;
  sweep_state_t      state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // External writes are only accepted in IDLE, so sweep and writeback never collide on the array.
  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    sweep_busy  = 1'b0;
    sweep_done  = 1'b0;
    write_ready = 1'b0;
    sweep_wr_en = 1'b0;
    case (state)
      IDLE: begin
        write_ready = 1'b1;
        if (sweep_req) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        sweep_busy  = 1'b1;
        sweep_wr_en = 1'b1;
        ptr_next    = ptr + 1'b1;
        if (ptr == LAST_PTR) begin
          state_next = DONE;
        end
      end
      DONE: begin
        sweep_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sweep_addr = ptr;

endmodule

// File: rtl/register_file_pipelined.sv
// Register file with two registered read ports, one write port and a sweep-clear sequencer.
// Define REGFILE_WRITE_BYPASS_EN for write-first reads on a same-cycle address match.
module register_file_pipelined
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input logic                      clock,
  input logic                      clear,
  register_file_pipelined_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sweep_busy;
  logic              sweep_done;
  logic              write_ready;
  logic              sweep_wr_en;
  logic [ADDR_W-1:0] sweep_addr;
  logic              write_en;

  logic [DATA_W-1:0] next_data1;
  logic [DATA_W-1:0] next_data2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              valid;

  regfile_sweep_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_sweep_ctrl (
    .clock      (clock),
    .clear      (clear),
    .sweep_req  (bus.sweep_req),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done),
    .write_ready(write_ready),
    .sweep_wr_en(sweep_wr_en),
    .sweep_addr (sweep_addr)
  );

  assign write_en = bus.regWrite & write_ready;

  // Read-port source: array contents, optionally overridden by this cycle's array update.
  always_comb begin
    next_data1 = mem[bus.read_reg1];
    next_data2 = mem[bus.read_reg2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (sweep_wr_en && (bus.read_reg1 == sweep_addr)) begin
      next_data1 = '0;
    end else if (write_en && (bus.read_reg1 == bus.write_reg)) begin
      next_data1 = bus.write_data;
    end
    if (sweep_wr_en && (bus.read_reg2 == sweep_addr)) begin
      next_data2 = '0;
    end else if (write_en && (bus.read_reg2 == bus.write_reg)) begin
      next_data2 = bus.write_data;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (sweep_wr_en) begin
      mem[sweep_addr] <= '0;
    end else if (write_en) begin
      mem[bus.write_reg] <= bus.write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      data1 <= '0;
      data2 <= '0;
      valid <= 1'b0;
    end else begin
      valid <= bus.rd_en;
      if (bus.rd_en) begin
        data1 <= next_data1;
        data2 <= next_data2;
      end
    end
  end

  assign bus.read_data1  = data1;
  assign bus.read_data2  = data2;
  assign bus.read_valid  = valid;
  assign bus.write_ready = write_ready;
  assign bus.sweep_busy  = sweep_busy;
  assign bus.sweep_done  = sweep_done;

endmodule

// File: tb/tb_register_file_pipelined.sv
// Bench for register_file_pipelined: array/phase model checked every cycle plus literal expectations.
module tb_register_file_pipelined;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clock = 1'b0;
  logic clear = 1'b1;

  register_file_pipelined_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  register_file_pipelined #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model: phase -1 is idle, 0..DEPTH-1 is the entry being swept, DEPTH is the done cycle.
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_rd1   = '0;
  logic [15:0] m_rd2   = '0;
  logic        m_valid = 1'b0;
  int          m_phase = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] addr);
    logic [15:0] v;
    v = m_mem[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (m_phase >= 0 && m_phase < DEPTH && int'(addr) == m_phase) v = '0;
    else if (m_phase == -1 && bus.regWrite && addr == bus.write_reg) v = bus.write_data;
`endif
    return v;
  endfunction

  always @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_rd1   <= '0;
      m_rd2   <= '0;
      m_valid <= 1'b0;
      m_phase <= -1;
    end else begin
      m_valid <= bus.rd_en;
      if (bus.rd_en) begin
        m_rd1 <= model_read(bus.read_reg1);
        m_rd2 <= model_read(bus.read_reg2);
      end
      if (m_phase >= 0 && m_phase < DEPTH) m_mem[4'(m_phase)] <= '0;
      else if (m_phase == -1 && bus.regWrite) m_mem[bus.write_reg] <= bus.write_data;
      if (m_phase == -1) m_phase <= bus.sweep_req ? 0 : -1;
      else if (m_phase == DEPTH) m_phase <= -1;
      else m_phase <= m_phase + 1;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      checkOutput("model_read_data1", bus.read_data1, m_rd1);
      checkOutput("model_read_data2", bus.read_data2, m_rd2);
      checkOutput("model_read_valid", bus.read_valid, m_valid);
      checkOutput("model_sweep_busy", bus.sweep_busy, (m_phase >= 0 && m_phase < DEPTH));
      checkOutput("model_sweep_done", bus.sweep_done, (m_phase == DEPTH));
      checkOutput("model_write_ready", bus.write_ready, (m_phase == -1));
    end
  end

  task automatic applyStimulus(input logic [3:0] r1, input logic [3:0] r2, input logic ren,
                               input logic [3:0] wr, input logic [15:0] wd, input logic wen,
                               input logic sreq);
    bus.read_reg1  = r1;
    bus.read_reg2  = r2;
    bus.rd_en      = ren;
    bus.write_reg  = wr;
    bus.write_data = wd;
    bus.regWrite   = wen;
    bus.sweep_req  = sreq;
    @(negedge clock);
  endtask

  task automatic idle();
    applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_n;
    int done_n;
    logic [15:0] exp_collide;

    bus.read_reg1 = '0; bus.read_reg2 = '0; bus.rd_en = 1'b0;
    bus.write_reg = '0; bus.write_data = '0; bus.regWrite = 1'b0; bus.sweep_req = 1'b0;
    @(negedge clock);
    clear  = 1'b0;
    cmp_en = 1'b1;
    $display("[TB] reset state");
    checkOutput("reset_read_data1", bus.read_data1, 32'h0);
    checkOutput("reset_read_valid", bus.read_valid, 32'h0);
    checkOutput("reset_write_ready", bus.write_ready, 32'h1);
    checkOutput("reset_sweep_busy", bus.sweep_busy, 32'h0);

    applyStimulus(4'd2, 4'd3, 1'b1, 4'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("post_reset_rd1", bus.read_data1, 32'h0);
    checkOutput("post_reset_rd2", bus.read_data2, 32'h0);
    checkOutput("post_reset_valid", bus.read_valid, 32'h1);

    $display("[TB] basic write/read");
    applyStimulus(4'd0, 4'd0, 1'b0, 4'd1, 16'h0001, 1'b1, 1'b0);
    applyStimulus(4'd1, 4'd0, 1'b1, 4'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("basic_rd1", bus.read_data1, 32'h0001);
    checkOutput("basic_valid", bus.read_valid, 32'h1);
    idle();
    checkOutput("hold_rd1", bus.read_data1, 32'h0001);
    checkOutput("hold_valid", bus.read_valid, 32'h0);

    $display("[TB] same-cycle collision");
    applyStimulus(4'd0, 4'd0, 1'b0, 4'd5, 16'h00AA, 1'b1, 1'b0);
    applyStimulus(4'd5, 4'd5, 1'b1, 4'd5, 16'h1234, 1'b1, 1'b0);
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_collide = 16'h1234;
`else
    exp_collide = 16'h00AA;
`endif
    checkOutput("collide_rd1", bus.read_data1, 32'(exp_collide));
    checkOutput("collide_rd2", bus.read_data2, 32'(exp_collide));
    applyStimulus(4'd5, 4'd1, 1'b1, 4'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("collide_next_rd1", bus.read_data1, 32'h1234);
    checkOutput("collide_next_rd2", bus.read_data2, 32'h0001);

    $display("[TB] full sweep");
    for (int r = 0; r < DEPTH; r++) applyStimulus(4'd0, 4'd0, 1'b0, 4'(r), 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 40 && done_n == 0; i++) begin
      if (bus.sweep_busy) busy_n++;
      if (bus.sweep_done) done_n++;
      if (done_n == 0)
        applyStimulus(4'(i), 4'(i + 8), 1'b1, 4'd3, 16'h5555, (i == 4), 1'b0);
    end
    checkOutput("sweep_busy_cycles", busy_n, 32'd16);
    checkOutput("sweep_done_pulses", done_n, 32'd1);
    idle();
    checkOutput("after_sweep_ready", bus.write_ready, 32'h1);
    for (int r = 0; r < DEPTH / 2; r++) begin
      applyStimulus(4'(2 * r), 4'(2 * r + 1), 1'b1, 4'd0, 16'h0, 1'b0, 1'b0);
      checkOutput("swept_rd1", bus.read_data1, 32'h0);
      checkOutput("swept_rd2", bus.read_data2, 32'h0);
    end

    $display("[TB] clear mid-sweep");
    for (int r = 0; r < 4; r++) applyStimulus(4'd0, 4'd0, 1'b0, 4'(r + 8), 16'hABCD, 1'b1, 1'b0);
    applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle();
    checkOutput("mid_sweep_busy", bus.sweep_busy, 32'h1);
    clear = 1'b1;
    idle();
    clear = 1'b0;
    checkOutput("abort_busy", bus.sweep_busy, 32'h0);
    checkOutput("abort_ready", bus.write_ready, 32'h1);
    done_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.sweep_done) done_n++;
      idle();
    end
    checkOutput("abort_no_done", done_n, 32'd0);
    applyStimulus(4'd8, 4'd11, 1'b1, 4'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("abort_rd1", bus.read_data1, 32'h0);
    checkOutput("abort_rd2", bus.read_data2, 32'h0);

    $display("[TB] held sweep request");
    applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    done_n = 0;
    for (int i = 0; i < 40 && done_n == 0; i++) begin
      if (bus.sweep_done) done_n++;
      else applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    end
    checkOutput("held_done_pulses", done_n, 32'd1);
    applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("held_idle_busy", bus.sweep_busy, 32'h0);
    checkOutput("held_idle_done", bus.sweep_done, 32'h0);
    applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("held_restart_busy", bus.sweep_busy, 32'h1);
    done_n = 0;
    for (int i = 0; i < 40 && done_n == 0; i++) begin
      if (bus.sweep_done) done_n++;
      else idle();
    end
    checkOutput("second_done_pulses", done_n, 32'd1);
    idle();
    idle();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
